multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 SHALL provide parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL provide parameter CNT_N, default 15, consecutive differing enabled samples minus one needed to toggle a channel.
REQ-003 SHALL provide parameter HOLD_N, default 1023, enabled samples pressed before long-press detection.
REQ-004 SHALL provide parameter RPT_N, default 255, auto-repeat period in enabled samples minus one; 0 disables repeat.
REQ-005 SHALL provide parameter ACTIVE_LOW, default 1, pressed level is 0 when 1 and 1 when 0.
REQ-006 SHALL provide: i_clk  input  1  clock, all logic on rising edge.
REQ-007 SHALL provide: i_rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL provide: i_en  input  1  sample strobe; counters advance only when high.
REQ-009 SHALL provide: i_in  input  N_CH  raw asynchronous switch inputs.
REQ-010 SHALL provide: o_debounced  output  N_CH  debounced level per channel.
REQ-011 SHALL provide: o_pos  output  N_CH  one-cycle pulse on debounced rise.
REQ-012 SHALL provide: o_neg  output  N_CH  one-cycle pulse on debounced fall.
REQ-013 SHALL provide: o_long  output  N_CH  one-cycle pulse at long-press threshold.
REQ-014 SHALL provide: o_held  output  N_CH  level, high from long-press until release.
REQ-015 SHALL provide: o_rpt  output  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-016 Each channel SHALL pass i_in through a two-flop synchronizer; channels SHALL be fully independent.
REQ-017 Debounce counter width SHALL be $clog2(CNT_N+1); when sync equals o_debounced, counter SHALL reload CNT_N every cycle regardless of i_en.
REQ-018 When sync differs and i_en=1: counter>0 -> decrement; counter==0 -> o_debounced toggles next edge, counter reloads CNT_N.
REQ-019 Differing with i_en=0 SHALL hold counter; latency input change -> o_debounced toggle = 2 sync cycles + CNT_N+1 enabled samples.
REQ-020 o_pos/o_neg SHALL be registered, asserted in exactly the cycle o_debounced shows the new level, width one cycle.
REQ-021 "Pressed" SHALL mean o_debounced equals the pressed level per ACTIVE_LOW.
REQ-022 Per-channel state machine: IDLE (released) -> PRESS on debounced press; PRESS -> HELD when hold counter reaches HOLD_N; PRESS/HELD -> IDLE on debounced release.
REQ-023 Hold counter SHALL clear in IDLE, increment on i_en in PRESS, width $clog2(HOLD_N+1); PRESS->HELD transition SHALL pulse o_long once and set o_held.
REQ-024 In HELD with RPT_N>0, repeat counter SHALL load RPT_N on entry, decrement on i_en, pulse o_rpt and reload at 0 (first o_rpt RPT_N+1 samples after o_long).
REQ-025 o_long and o_rpt SHALL never assert in the same cycle; o_rpt SHALL never assert in IDLE.
REQ-026 Release in HELD SHALL clear o_held in the same cycle the release edge pulse appears, with no o_rpt that cycle.
REQ-027 Bounce shorter than CNT_N+1 enabled samples SHALL produce no output change and SHALL restart the count.

Reset
REQ-028 On i_rst low, all synchronizer flops and o_debounced SHALL go to released level (1 if ACTIVE_LOW, else 0) immediately.
REQ-029 On reset, debounce counters SHALL load CNT_N, hold/repeat counters 0, state IDLE, o_pos/o_neg/o_long/o_rpt/o_held 0.
REQ-030 Reset asserted mid-hold SHALL abort without emitting any pulse; release SHALL be synchronous to i_clk.

Verification (N_CH=2, CNT_N=3, HOLD_N=7, RPT_N=3, ACTIVE_LOW=1, i_en=1 unless noted)
REQ-031 Ch0 1->0 held steady -> o_debounced[0] falls 6 cycles later with o_neg[0] same cycle; ch1 unchanged.
REQ-032 Ch0 low 3 cycles then high (glitch) -> no o_debounced/o_neg change on either channel.
REQ-033 Ch0 held low 30 cycles -> o_long[0] 8 cycles after press, o_held[0]=1, o_rpt[0] every 4 cycles thereafter.
REQ-034 Ch0 held, then released -> o_pos[0] and o_held[0] fall same cycle, no further o_rpt.
REQ-035 i_en pulsed every 4th cycle, ch1 low -> toggle after 2 sync cycles + 4 enabled samples; counter frozen between strobes.
REQ-036 i_rst low during HELD -> all outputs 0, o_debounced=2'b11 immediately; after release, stable high input yields no pulses.

Source files
------------

// File: rtl/multi_debounce.sv
// multi_debounce: per-channel synchronizer, debouncer, edge pulses, long-press and auto-repeat detection
module multi_debounce #(
  parameter int N_CH = 4,
  parameter int CNT_N = 15,
  parameter int HOLD_N = 1023,
  parameter int RPT_N = 255,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_debounced,
  output logic [N_CH-1:0] o_pos,
  output logic [N_CH-1:0] o_neg,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_held,
  output logic [N_CH-1:0] o_rpt
);
  localparam logic REL = ACTIVE_LOW;
  localparam int CW = CNT_N > 0 ? $clog2(CNT_N + 1) : 1;
  localparam int HW = HOLD_N > 0 ? $clog2(HOLD_N + 1) : 1;
  localparam int RW = RPT_N > 0 ? $clog2(RPT_N + 1) : 1;
  localparam logic [CW-1:0] CNT_L = CW'(CNT_N);
  localparam logic [HW-1:0] HOLD_L = HW'(HOLD_N);
  localparam logic [RW-1:0] RPT_L = RW'(RPT_N);
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD} state_t;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic r_s1, r_s2, r_deb, r_pos, r_neg, r_long, r_rpt;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold, w_hold;
    logic [RW-1:0] r_rc, w_rc;
    state_t r_st, w_st;
    logic w_diff, w_tog, w_press, w_rel, w_long, w_rpt;
    assign w_diff = r_s2 != r_deb;
    assign w_tog = w_diff && i_en && r_cnt == '0;
    assign w_press = w_tog && r_s2 != REL;
    assign w_rel = w_tog && r_s2 == REL;
    always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
        r_s1 <= REL;
        r_s2 <= REL;
        r_deb <= REL;
        r_cnt <= CNT_L;
        r_pos <= 1'b0;
        r_neg <= 1'b0;
      end else begin
        r_s1 <= i_in[c];
        r_s2 <= r_s1;
        r_deb <= w_tog ? ~r_deb : r_deb;
        r_cnt <= (!w_diff || w_tog) ? CNT_L : i_en ? r_cnt - 1'b1 : r_cnt;
        r_pos <= w_tog && r_s2;
        r_neg <= w_tog && !r_s2;
      end
    always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
        r_st <= S_IDLE;
        r_hold <= '0;
        r_rc <= '0;
        r_long <= 1'b0;
        r_rpt <= 1'b0;
      end else begin
        r_st <= w_st;
        r_hold <= w_hold;
        r_rc <= w_rc;
        r_long <= w_long;
        r_rpt <= w_rpt;
      end
    // press/release follow the debounced toggle so o_held drops with the release edge pulse
    always_comb begin
      w_st = r_st;
      w_hold = r_hold;
      w_rc = r_rc;
      w_long = 1'b0;
      w_rpt = 1'b0;
      case (r_st)
        S_IDLE: begin
          w_hold = '0;
          w_rc = '0;
          w_st = w_press ? S_PRESS : S_IDLE;
        end
        S_PRESS:
          if (w_rel) w_st = S_IDLE;
          else if (r_hold == HOLD_L) begin
            w_st = S_HELD;
            w_long = 1'b1;
            w_rc = RPT_L;
          end else if (i_en) w_hold = r_hold + 1'b1;
        S_HELD:
          if (w_rel) w_st = S_IDLE;
          else if (RPT_N > 0 && i_en) begin
            w_rpt = r_rc == '0;
            w_rc = w_rpt ? RPT_L : r_rc - 1'b1;
          end
        default: w_st = S_IDLE;
      endcase
    end
    assign o_debounced[c] = r_deb;
    assign o_pos[c] = r_pos;
    assign o_neg[c] = r_neg;
    assign o_long[c] = r_long;
    assign o_rpt[c] = r_rpt;
    assign o_held[c] = r_st == S_HELD;
  end
endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: table-driven, directed and randomized checks of multi_debounce against a reference model
module tb_multi_debounce;
  localparam int N = 2, CN = 3, HN = 7, RN = 3;
  logic i_clk = 1'b0, i_rst = 1'b0, i_en = 1'b1;
  logic [N-1:0] i_in = '1;
  logic [N-1:0] o_debounced, o_pos, o_neg, o_long, o_held, o_rpt;
  logic [6*N-1:0] act;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic en;
    logic [N-1:0] in;
    int n;
    logic [6*N-1:0] exp;
  } vec_t;
  multi_debounce #(.N_CH(N), .CNT_N(CN), .HOLD_N(HN), .RPT_N(RN), .ACTIVE_LOW(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_in(i_in),
    .o_debounced(o_debounced), .o_pos(o_pos), .o_neg(o_neg),
    .o_long(o_long), .o_held(o_held), .o_rpt(o_rpt)
  );
  always #5 i_clk = ~i_clk;
  assign act = {o_debounced, o_pos, o_neg, o_long, o_held, o_rpt};
  // reference model: sync delay line, count of consecutive enabled differing samples,
  // enabled samples spent pressed, enabled samples since entering held
  logic [N-1:0] m_sa, m_sb, m_deb, m_pos, m_neg, m_long, m_held, m_rpt;
  int m_run[N], m_age[N], m_rage[N];
  function automatic void mdl_reset();
    m_sa = '1; m_sb = '1; m_deb = '1;
    m_pos = '0; m_neg = '0; m_long = '0; m_held = '0; m_rpt = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_age[c] = 0; m_rage[c] = 0;
    end
  endfunction
  function automatic void mdl_step(input logic en, input logic [N-1:0] in);
    bit tog;
    for (int c = 0; c < N; c++) begin
      tog = m_sb[c] != m_deb[c] && en && m_run[c] == CN;
      m_pos[c] = 1'b0; m_neg[c] = 1'b0; m_long[c] = 1'b0; m_rpt[c] = 1'b0;
      if (!m_deb[c] && !tog) begin
        if (!m_held[c]) begin
          if (m_age[c] == HN) begin
            m_long[c] = 1'b1; m_held[c] = 1'b1; m_rage[c] = 0;
          end else if (en) m_age[c]++;
        end else if (RN > 0 && en) begin
          m_rage[c]++;
          if (m_rage[c] == RN + 1) begin
            m_rpt[c] = 1'b1; m_rage[c] = 0;
          end
        end
      end else begin
        m_held[c] = 1'b0; m_age[c] = 0;
      end
      m_run[c] = (m_sb[c] == m_deb[c] || tog) ? 0 : m_run[c] + (en ? 1 : 0);
      if (tog) begin
        m_pos[c] = m_sb[c]; m_neg[c] = !m_sb[c]; m_deb[c] = m_sb[c];
      end
      m_sb[c] = m_sa[c]; m_sa[c] = in[c];
    end
  endfunction
  task automatic check(input string nm, input logic [6*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got deb/pos/neg/long/held/rpt=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic en, input logic [N-1:0] in);
    @(negedge i_clk);
    i_en = en; i_in = in;
    @(posedge i_clk);
    mdl_step(en, in);
    #1 check("model", {m_deb, m_pos, m_neg, m_long, m_held, m_rpt});
  endtask
  function automatic vec_t mk(input int n, input logic [N-1:0] in, input logic [N-1:0] deb, pos, neg, lng, hld, rpt);
    vec_t v;
    v.en = 1'b1; v.in = in; v.n = n; v.exp = {deb, pos, neg, lng, hld, rpt};
    return v;
  endfunction
  initial begin
    vec_t tbl[17];
    logic [N-1:0] seen, nx;
    tbl[0]  = mk(5, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    tbl[2]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[3]  = mk(6, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[4]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00);
    tbl[5]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[6]  = mk(2, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[7]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    tbl[8]  = mk(3, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[9]  = mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    tbl[10] = mk(3, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[11] = mk(1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    tbl[12] = mk(1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    tbl[13] = mk(1, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[14] = mk(4, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[15] = mk(3, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    tbl[16] = mk(6, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    mdl_reset();
    #12 check("reset", {2'b11, 10'b0});
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].en, tbl[i].in);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    for (int k = 0; k < 16; k++) begin
      step(k % 4 == 3, 2'b01);
      if (k == 14) check("strobe_pre", {2'b11, 10'b0});
      if (k == 15) check("strobe_fall", {2'b01, 2'b00, 2'b10, 6'b0});
    end
    repeat (12) step(1'b1, 2'b11);
    repeat (20) step(1'b1, 2'b10);
    check("held_pre_rst", {2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00});
    @(negedge i_clk);
    i_rst = 1'b0;
    i_in = 2'b11;
    #1 check("rst_async", {2'b11, 10'b0});
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    mdl_reset();
    seen = '0;
    repeat (20) begin
      step(1'b1, 2'b11);
      seen |= o_pos | o_neg | o_long | o_rpt | o_held | ~o_debounced;
    end
    n_cmp++;
    if (seen !== '0) begin
      n_bad++;
      $display("FAIL post_rst_quiet: got activity=%b want 00", seen);
    end
    for (int k = 0; k < 600; k++) begin
      nx = i_in;
      for (int c = 0; c < N; c++) if ($urandom_range(23) == 0) nx[c] = ~nx[c];
      step($urandom_range(3) != 0, nx);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
